// File: rtl/jt5205_adpcm_dec_if.sv
// Bundle of timing-stage strobes, ADPCM nibble input and decoded sample output
// for the MSM5205 decoder stage.
`timescale 1ns/1ps

interface jt5205_adpcm_dec_if #(parameter int OUTW = 12);
  logic                   cen;
  logic                   cen_lo;
  logic                   chip_rst;
  logic [3:0]             din;
  logic signed [OUTW-1:0] sound;
  logic                   sample;

  modport master (output cen, cen_lo, chip_rst, din, input sound, sample);
  modport slave  (input cen, cen_lo, chip_rst, din, output sound, sample);
endinterface

// File: rtl/jt5205_adpcm_dec.sv
// MSM5205 / Dialogic ADPCM decoder: latches a nibble per sample strobe and
// updates step index and 12-bit accumulator over a three-tick cen-paced pipeline.
`timescale 1ns/1ps

module jt5205_adpcm_dec #(parameter int OUTW = 12) (
  input  logic             clk,
  input  logic             rst_n,
  jt5205_adpcm_dec_if.slave bus
);

  localparam logic [10:0] STEP [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  logic [3:0]             nibble;
  logic                   v1;
  logic                   v2;
  logic [12:0]            diff_r;
  logic                   sign_r;
  logic [2:0]             mag_r;
  logic signed [11:0]     acc;
  logic [5:0]             idx;

  logic [12:0]            step13;
  logic [12:0]            diff_c;
  logic signed [13:0]     acc_sum;
  logic signed [11:0]     acc_sat;
  logic signed [OUTW-1:0] sound_next;
  logic signed [6:0]      delta;
  logic signed [6:0]      idx_sum;
  logic [5:0]             idx_next;

  // Magnitude-weighted difference from the step of the current index.
  always_comb begin
    step13 = {2'b00, STEP[idx]};
    diff_c = (step13 >> 3)
           + (nibble[2] ? step13        : 13'd0)
           + (nibble[1] ? (step13 >> 1) : 13'd0)
           + (nibble[0] ? (step13 >> 2) : 13'd0);
  end

  always_comb begin
    if (sign_r)
      acc_sum = {{2{acc[11]}}, acc} - {1'b0, diff_r};
    else
      acc_sum = {{2{acc[11]}}, acc} + {1'b0, diff_r};
    if (acc_sum > 14'sd2047)
      acc_sat = 12'sd2047;
    else if (acc_sum < -14'sd2048)
      acc_sat = 12'sh800;
    else
      acc_sat = acc_sum[11:0];
    sound_next = OUTW'(acc_sat) <<< (OUTW - 12);
  end

  always_comb begin
    case (mag_r)
      3'd4:    delta = 7'sd2;
      3'd5:    delta = 7'sd4;
      3'd6:    delta = 7'sd6;
      3'd7:    delta = 7'sd8;
      default: delta = -7'sd1;
    endcase
    idx_sum = $signed({1'b0, idx}) + delta;
    if (idx_sum < 7'sd0)
      idx_next = 6'd0;
    else if (idx_sum > 7'sd48)
      idx_next = 6'd48;
    else
      idx_next = idx_sum[5:0];
  end

  // Overlapping strobes simply refill stage 0; stages 1 and 2 finish with what they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble     <= 4'd0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      diff_r     <= 13'd0;
      sign_r     <= 1'b0;
      mag_r      <= 3'd0;
      acc        <= 12'sd0;
      idx        <= 6'd0;
      bus.sound  <= '0;
      bus.sample <= 1'b0;
    end else begin
      bus.sample <= 1'b0;
      if (bus.cen) begin
        if (bus.chip_rst) begin
          acc       <= 12'sd0;
          idx       <= 6'd0;
          v1        <= 1'b0;
          v2        <= 1'b0;
          bus.sound <= '0;
        end else begin
          if (bus.cen_lo)
            nibble <= bus.din;
          v1 <= bus.cen_lo;
          v2 <= v1;
          if (v1) begin
            diff_r <= diff_c;
            sign_r <= nibble[3];
            mag_r  <= nibble[2:0];
          end
          if (v2) begin
            acc        <= acc_sat;
            idx        <= idx_next;
            bus.sound  <= sound_next;
            bus.sample <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt5205_adpcm_dec.sv
// Bench for jt5205_adpcm_dec: 12- and 16-bit builds side by side, expected
// samples queued at each strobe and checked when the sample pulse appears.
`timescale 1ns/1ps

module tb_jt5205_adpcm_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt5205_adpcm_dec_if #(.OUTW(12)) bus12 ();
  jt5205_adpcm_dec_if #(.OUTW(16)) bus16 ();

  assign bus16.cen      = bus12.cen;
  assign bus16.cen_lo   = bus12.cen_lo;
  assign bus16.chip_rst = bus12.chip_rst;
  assign bus16.din      = bus12.din;

  jt5205_adpcm_dec #(.OUTW(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));
  jt5205_adpcm_dec #(.OUTW(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  typedef struct { int snd; int due; } exp_t;
  typedef struct { logic [3:0] din; int expSound; } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  int checks = 0;
  int failures = 0;
  int tickCount = 0;
  int mAcc = 0;
  int mIdx = 0;

  int STEP[49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                   73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
                   253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724,
                   796, 876, 963, 1060, 1166, 1282, 1411, 1552};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Decode one nibble in the model using the step at index si.
  task automatic modelApply(input logic [3:0] d, input int si);
    int st, diff;
    int deltas[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
    st = STEP[si];
    diff = st / 8 + (d[2] ? st : 0) + (d[1] ? st / 2 : 0) + (d[0] ? st / 4 : 0);
    mAcc = d[3] ? mAcc - diff : mAcc + diff;
    if (mAcc > 2047) mAcc = 2047;
    if (mAcc < -2048) mAcc = -2048;
    mIdx = mIdx + deltas[d[2:0]];
    if (mIdx < 0) mIdx = 0;
    if (mIdx > 48) mIdx = 48;
  endtask

  task automatic modelReset();
    mAcc = 0;
    mIdx = 0;
    sbq.delete();
  endtask

  // One clk with cen high followed by one clk with cen low.
  task automatic applyStimulus(input logic lo, input logic [3:0] d, input logic crst);
    @(negedge clk);
    bus12.cen      = 1'b1;
    bus12.cen_lo   = lo;
    bus12.din      = d;
    bus12.chip_rst = crst;
    @(posedge clk);
    tickCount++;
    @(negedge clk);
    bus12.cen      = 1'b0;
    bus12.cen_lo   = 1'b0;
    bus12.chip_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0);
  endtask

  task automatic pushExp(input int snd);
    sbq.push_back('{snd: snd, due: tickCount + 2});
  endtask

  task automatic sendModel(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0);
    modelApply(d, mIdx);
    pushExp(mAcc);
    idle(47);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus12.sample) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_sample: got strobe at tick %0d, expected none", tickCount);
      end else begin
        e = sbq.pop_front();
        checkOutput("sound12", bus12.sound, e.snd);
        checkOutput("sound16", bus16.sound, e.snd * 16);
        checkOutput("sample16", int'(bus16.sample), 1);
        checkOutput("latency_tick", tickCount, e.due);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{din: 4'b0111, expSound: 30};
    vecs[1] = '{din: 4'b1111, expSound: -33};
    vecs[2] = '{din: 4'b0000, expSound: -24};
    vecs[3] = '{din: 4'b0011, expSound: 33};
    vecs[4] = '{din: 4'b1100, expSound: -34};
    vecs[5] = '{din: 4'b0101, expSound: 66};

    bus12.cen = 1'b0;
    bus12.cen_lo = 1'b0;
    bus12.chip_rst = 1'b0;
    bus12.din = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sound12", bus12.sound, 0);
    checkOutput("reset_sound16", bus16.sound, 0);
    checkOutput("reset_sample", int'(bus12.sample), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    $display("[TB] table-driven sequence from reset");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].din, 1'b0);
      modelApply(vecs[i].din, mIdx);
      pushExp(vecs[i].expSound);
      idle(47);
    end

    $display("[TB] chip_rst with a sample in flight");
    applyStimulus(1'b1, 4'b0111, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    modelReset();
    idle(5);
    checkOutput("chip_rst_sound", bus12.sound, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0101, 1'b1);
    idle(10);
    sendModel(4'b0111);

    $display("[TB] zero nibbles with index clamped at 0");
    applyStimulus(1'b0, 4'd0, 1'b1);
    modelReset();
    idle(3);
    checkOutput("chip_rst_clear", bus12.sound, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0);
      modelApply(4'b0000, mIdx);
      pushExp(2 * (i + 1));
      idle(47);
    end

    $display("[TB] positive then negative saturation");
    for (int i = 0; i < 40; i++) sendModel(4'b0111);
    idle(60);
    checkOutput("sat_hi_hold", bus12.sound, 2047);
    for (int i = 0; i < 40; i++) sendModel(4'b1111);
    idle(60);
    checkOutput("sat_lo_hold", bus12.sound, -2048);
    checkOutput("sat_lo_hold16", bus16.sound, -32768);

    $display("[TB] overlapping strobes");
    applyStimulus(1'b0, 4'd0, 1'b1);
    modelReset();
    idle(3);
    applyStimulus(1'b1, 4'b0111, 1'b0);
    modelApply(4'b0111, mIdx);
    pushExp(mAcc);
    applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'b0011, 1'b0);
    modelApply(4'b0011, mIdx);
    pushExp(mAcc);
    idle(47);
    begin
      int si;
      si = mIdx;
      applyStimulus(1'b1, 4'b0001, 1'b0);
      modelApply(4'b0001, si);
      pushExp(mAcc);
      applyStimulus(1'b1, 4'b0100, 1'b0);
      modelApply(4'b0100, si);
      pushExp(mAcc);
    end
    idle(47);
    sendModel(4'b0110);
    idle(60);
    checkOutput("idle_hold", bus12.sound, mAcc);

    $display("[TB] async reset mid-pipeline");
    sendModel(4'b0111);
    applyStimulus(1'b1, 4'b0111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_sound12", bus12.sound, 0);
    checkOutput("async_sound16", bus16.sound, 0);
    checkOutput("async_sample", int'(bus12.sample), 0);
    modelReset();
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    sendModel(4'b0111);
    sendModel(4'b1111);

    idle(10);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
